// File: rtl/fifo_rd_adapter.sv
// ============================================================================
// Module      : fifo_rd_adapter
// Description : Drain stage for sync_fifo. Turns the FIFO read/empty/rdData
//               interface (one-cycle registered read latency) into a
//               valid/ready stream through a small circular skid buffer.
//               fifo_read is computed from registered state and fifo_empty
//               only, so there is no combinational path from m_ready to the
//               FIFO read strobe.
// Options     : FIFO_RD_ADAPTER_STATS_EN - adds stat_words / stat_stalls
//               counters (delivered words, stalled cycles), cleared by rst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fifo_rd_adapter #(
  parameter int WIDTH     = 32,
  parameter int BUF_DEPTH = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               fifo_empty,
  input  logic [WIDTH-1:0]                   fifo_rdata,
  output logic                               fifo_read,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [WIDTH-1:0]                   m_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_count
`ifdef FIFO_RD_ADAPTER_STATS_EN
  ,
  output logic [31:0]                        stat_words,
  output logic [31:0]                        stat_stalls
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  // Occupancy is compared one bit wider so count + inflight cannot wrap.
  localparam logic [CNT_W:0]   OCC_LIMIT = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);

  // Buffer storage and control state
  logic [WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;

  logic             w_push;
  logic             w_pop;
  logic             w_credit;
  logic [CNT_W:0]   w_occupancy;
  logic [BUF_DEPTH-1:0] w_wen;

  // Pointers wrap at BUF_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Words already buffered plus the word still travelling out of the FIFO.
  assign w_occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign w_credit    = (w_occupancy < OCC_LIMIT);

  // Read only with a guaranteed free slot for the returning word.
  assign fifo_read = ~rst & ~flush & ~fifo_empty & w_credit;

  // A word returns the cycle after each read; a flush discards it.
  assign w_push = inflight_q & ~flush;
  assign w_pop  = m_valid & m_ready;

  assign m_valid   = (count_q != '0);
  assign m_data    = m_valid ? buf_q[rd_ptr_q] : '0;
  assign buf_count = count_q;

  // One write enable per buffer entry, decoded from the write pointer.
  generate
    for (genvar i = 0; i < BUF_DEPTH; i++) begin : g_wen
      assign w_wen[i] = w_push & (wr_ptr_q == PTR_W'(i));
    end
  endgenerate

  // Next-state for pointers, occupancy count and in-flight flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = fifo_read;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (w_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      // Push and pop together leave the count unchanged.
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers; reset also drops any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Capture the returning FIFO word into the entry at the write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (w_wen[i]) begin
          buf_q[i] <= fifo_rdata;
        end
      end
    end
  end

`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [31:0] stat_words_q;
  logic [31:0] stat_stalls_q;

  // Delivery and stall counters; they wrap and survive a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (w_pop) begin
        stat_words_q <= stat_words_q + 32'd1;
      end
      if (m_valid & ~m_ready) begin
        stat_stalls_q <= stat_stalls_q + 32'd1;
      end
    end
  end

  assign stat_words  = stat_words_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_adapter.sv
// ============================================================================
// Module      : tb_fifo_rd_adapter
// Description : Directed bench for fifo_rd_adapter driven from a behavioural
//               single-cycle-latency FIFO. A second instance with
//               BUF_DEPTH=2 is fed from an always-non-empty counting source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_rd_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, m_ready, m_ready2;
  logic        f_wr;
  logic [31:0] f_wdata;

  // Behavioural FIFO: registered empty flag, rdData valid the cycle after read.
  logic [31:0] fmem [0:63];
  logic [31:0] fwp = '0;
  logic [31:0] frp = '0;
  logic [31:0] fifo_rdata = '0;
  logic        fifo_empty;
  logic        fifo_read, m_valid;
  logic [31:0] m_data;
  logic [1:0]  buf_count;

  // Second instance: source never empty, returns 1, 2, 3, ...
  logic        fifo_empty2 = 1'b0;
  logic [31:0] fifo_rdata2 = '0;
  logic        fifo_read2, m_valid2;
  logic [31:0] m_data2;
  logic [1:0]  buf_count2;

`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [31:0] stat_words, stat_stalls, stat_words2, stat_stalls2;
`endif

  fifo_rd_adapter #(.WIDTH(32), .BUF_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_read(fifo_read),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .buf_count(buf_count)
`ifdef FIFO_RD_ADAPTER_STATS_EN
    , .stat_words(stat_words), .stat_stalls(stat_stalls)
`endif
  );

  fifo_rd_adapter #(.WIDTH(32), .BUF_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .fifo_empty(fifo_empty2), .fifo_rdata(fifo_rdata2), .fifo_read(fifo_read2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .buf_count(buf_count2)
`ifdef FIFO_RD_ADAPTER_STATS_EN
    , .stat_words(stat_words2), .stat_stalls(stat_stalls2)
`endif
  );

  assign fifo_empty = (fwp == frp);

  always @(posedge clk) begin
    if (f_wr) begin
      fmem[fwp[5:0]] <= f_wdata;
      fwp <= fwp + 1;
    end
    if (fifo_read) begin
      fifo_rdata <= fmem[frp[5:0]];
      frp <= frp + 1;
    end
    if (fifo_read2) begin
      fifo_rdata2 <= fifo_rdata2 + 1;
    end
  end

  // Cycle counter and stream monitors (sampled mid-cycle).
  int          cyc = 0;
  logic [31:0] got[$];
  int          got_cyc[$];
  logic [31:0] got2[$];
  int          n_reads = 0, n_rd_empty = 0, n_stalls = 0, first_valid_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      got_cyc.push_back(cyc);
    end
    if (fifo_read)               n_reads++;
    if (fifo_read && fifo_empty) n_rd_empty++;
    if (m_valid && !m_ready)     n_stalls++;
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (m_valid2 && m_ready2)    got2.push_back(m_data2);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write n words base+0 .. base+n-1 into the FIFO, one per cycle.
  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      f_wdata = base + i;
      f_wr    = 1'b1;
      tick();
    end
    f_wr = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int k = 0; k < budget && got.size() < n; k++) tick();
  endtask

  int wcyc;
  int beats;

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; m_ready2 = 1'b0;
    f_wr = 1'b0; f_wdata = '0;
    tick(); tick();

    // Reset state
    check_eq("rst_fifo_read", fifo_read, 0);
    check_eq("rst_m_valid",   m_valid,   0);
    check_eq("rst_m_data",    m_data,    0);
    check_eq("rst_buf_count", buf_count, 0);
    rst = 1'b0;
    tick();

    // 8 words at full rate: write lands on the next edge, m_valid two
    // cycles after that, then back-to-back beats.
    m_ready = 1'b1;
    got.delete(); got_cyc.delete();
    first_valid_cyc = -1;
    wcyc = cyc;
    load(32'h1, 8);
    wait_got(8, 30);
    check_eq("t1_first_valid", first_valid_cyc, wcyc + 3);
    check_eq("t1_beats", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        check_eq($sformatf("t1_data%0d", i), got[i], i + 1);
        check_eq($sformatf("t1_gap%0d", i), got_cyc[i], got_cyc[0] + i);
      end
    end

    // Consumer stalled: three reads fill the buffer, head held.
    m_ready = 1'b0;
    tick();
    got.delete(); got_cyc.delete();
    n_reads = 0;
    load(32'h1, 5);
    repeat (6) tick();
    check_eq("t2_reads",     n_reads,   3);
    check_eq("t2_buf_count", buf_count, 3);
    check_eq("t2_m_valid",   m_valid,   1);
    check_eq("t2_m_data",    m_data,    1);
    check_eq("t2_fifo_left", fifo_empty, 0);
    repeat (3) tick();
    check_eq("t2_m_data_held", m_data, 1);
    check_eq("t2_no_more_reads", n_reads, 3);
    m_ready = 1'b1;
    wait_got(5, 20);
    check_eq("t2_beats", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) check_eq($sformatf("t2_data%0d", i), got[i], i + 1);
    end

    // m_ready toggling over 16 words; restart counters with a reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got.delete(); got_cyc.delete();
    n_stalls = 0;
    for (int t = 0; t < 120 && got.size() < 16; t++) begin
      m_ready = (t % 2 == 0);
      f_wr    = (t < 16);
      f_wdata = 32'h100 + t;
      tick();
    end
    f_wr    = 1'b0;
    m_ready = 1'b1;
    repeat (4) tick();
    check_eq("t3_beats", got.size(), 16);
    check_eq("t3_drained", m_valid, 0);
    for (int i = 0; i < 16; i++) begin
      if (i < got.size()) check_eq($sformatf("t3_data%0d", i), got[i], 32'h100 + i);
    end
`ifdef FIFO_RD_ADAPTER_STATS_EN
    check_eq("t3_stat_words",  stat_words,  16);
    check_eq("t3_stat_stalls", stat_stalls, n_stalls);
`endif

    // Flush while a read is in flight: that word is lost, next FIFO word follows.
    m_ready = 1'b0;
    tick();
    got.delete(); got_cyc.delete();
    load(32'hB1, 5);
    repeat (6) tick();
    check_eq("t4_full", buf_count, 3);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check_eq("t4_after_pop", buf_count, 2);
    check_eq("t4_read_issued", fifo_read, 1);
    tick();
    flush = 1'b1;
    check_eq("t4_flush_blocks_read", fifo_read, 0);
    tick();
    flush = 1'b0;
    check_eq("t4_m_valid",   m_valid,   0);
    check_eq("t4_buf_count", buf_count, 0);
    check_eq("t4_m_data",    m_data,    0);
    for (int k = 0; k < 10 && !m_valid; k++) tick();
    check_eq("t4_next_valid", m_valid, 1);
    check_eq("t4_next_data",  m_data,  32'hB5);
    m_ready = 1'b1;
    wait_got(2, 10);
    check_eq("t4_beats", got.size(), 2);
    if (got.size() == 2) check_eq("t4_second_word", got[1], 32'hB5);

    // Reset with two words buffered and one in flight.
    m_ready = 1'b0;
    tick();
    got.delete(); got_cyc.delete();
    load(32'hC1, 5);
    repeat (6) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    check_eq("t5_pre_count", buf_count, 2);
    rst = 1'b1;
    check_eq("t5_rst_read", fifo_read, 0);
    tick();
    check_eq("t5_m_valid",   m_valid,   0);
    check_eq("t5_m_data",    m_data,    0);
    check_eq("t5_buf_count", buf_count, 0);
    check_eq("t5_fifo_read", fifo_read, 0);
    rst = 1'b0;
    got.delete(); got_cyc.delete();
    m_ready = 1'b1;
    wait_got(1, 10);
    check_eq("t5_beats", got.size(), 1);
    if (got.size() == 1) check_eq("t5_next_word", got[0], 32'hC5);
`ifdef FIFO_RD_ADAPTER_STATS_EN
    check_eq("t5_stats_cleared", stat_stalls, 0);
`endif

    // Two-entry build: reduced rate (credit allows a read whenever
    // count + inflight < 2), still in order with nothing lost.
    m_ready2 = 1'b1;
    repeat (10) tick();
    got2.delete();
    repeat (24) tick();
    beats = got2.size();
    check_eq("t6_rate_at_least_half", beats >= 12, 1);
    check_eq("t6_rate_below_full",    beats < 24,  1);
    for (int i = 1; i < got2.size(); i++) begin
      check_eq($sformatf("t6_order%0d", i), got2[i], got2[i-1] + 1);
    end
    check_eq("t6_count_bound", buf_count2 <= 2'd2, 1);

    check_eq("never_read_empty", n_rd_empty, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
